// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl: sequencing FSM for an 8-bit shift-add multiplier datapath sharing one data bus
module mult_seq_ctrl #(
  parameter int N_BITS = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic res_ack,
  input  logic AO,
  output logic busy,
  output logic host_drive,
  output logic res_lo_vld,
  output logic res_hi_vld,
  output logic load_A,
  output logic load_B,
  output logic clr_P,
  output logic load_P,
  output logic sel_sum,
  output logic shift_A,
  output logic lsb_out,
  output logic msb_out
);
  localparam int CW = $clog2(N_BITS);
  localparam logic [CW-1:0] CNT_MAX = CW'(N_BITS - 1);
  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, ITER, OUT_LO, OUT_HI} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= state == LOAD_B ? CNT_MAX : (state == ITER && cnt != '0) ? cnt - CW'(1) : cnt;
    end
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? LOAD_A : IDLE;
      LOAD_A:  state_nx = LOAD_B;
      LOAD_B:  state_nx = ITER;
      ITER:    state_nx = cnt == '0 ? OUT_LO : ITER;
      OUT_LO:  state_nx = res_ack ? OUT_HI : OUT_LO;
      OUT_HI:  state_nx = res_ack ? IDLE : OUT_HI;
      default: state_nx = IDLE;
    endcase
  end
  assign busy       = state != IDLE;
  assign host_drive = state == LOAD_A || state == LOAD_B;
  assign load_A     = state == LOAD_A;
  assign load_B     = state == LOAD_B;
  assign clr_P      = state == LOAD_B;
  assign load_P     = state == LOAD_B || state == ITER;
  assign shift_A    = state == ITER;
  assign sel_sum    = state == ITER && AO;
  assign lsb_out    = state == OUT_LO;
  assign res_lo_vld = state == OUT_LO;
  assign msb_out    = state == OUT_HI;
  assign res_hi_vld = state == OUT_HI;
endmodule

// File: tb/tb_mult_seq_ctrl.sv
// tb_mult_seq_ctrl: directed bench for mult_seq_ctrl driving a behavioural shift-add datapath
module tb_mult_seq_ctrl;
  logic clk = 0, rst_n = 1, start = 0, res_ack = 0;
  logic busy, host_drive, res_lo_vld, res_hi_vld, load_A, load_B, clr_P, load_P;
  logic sel_sum, shift_A, lsb_out, msb_out, AO;
  logic [7:0] host_data = 0, dp_a = 0, dp_b = 0, dp_p = 0, bus;
  logic [8:0] sa;
  logic [11:0] outs;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  mult_seq_ctrl #(.N_BITS(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .res_ack(res_ack), .AO(AO),
    .busy(busy), .host_drive(host_drive), .res_lo_vld(res_lo_vld), .res_hi_vld(res_hi_vld),
    .load_A(load_A), .load_B(load_B), .clr_P(clr_P), .load_P(load_P), .sel_sum(sel_sum),
    .shift_A(shift_A), .lsb_out(lsb_out), .msb_out(msb_out)
  );
  assign outs = {busy, host_drive, res_lo_vld, res_hi_vld, load_A, load_B,
                 clr_P, load_P, sel_sum, shift_A, lsb_out, msb_out};
  assign AO   = dp_a[0];
  assign bus  = host_drive ? host_data : lsb_out ? dp_a : msb_out ? dp_p : 8'h00;
  assign sa   = clr_P ? 9'd0 : sel_sum ? {1'b0, dp_p} + {1'b0, dp_b} : {1'b0, dp_p};
  always @(posedge clk) begin
    if (load_A) dp_a <= host_data;
    if (load_B) dp_b <= host_data;
    if (load_P) dp_p <= sa[8:1];
    if (shift_A) dp_a <= {sa[0], dp_a[7:1]};
  end
  task automatic launch(input logic [7:0] a, input logic [7:0] b, output logic [11:0] oa, output logic [11:0] ob);
    @(negedge clk) start = 1;
    @(negedge clk) begin start = 0; host_data = a; oa = outs; end
    @(negedge clk) begin host_data = b; ob = outs; end
    @(negedge clk) host_data = 8'h00;
  endtask
  task automatic test_reset;
    #2 rst_n = 0;
    #1 tests++;
    if (outs !== 12'h000) begin fails++; $display("FAIL reset outs=%h exp=000", outs); end
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk) tests++;
    if (outs !== 12'h000) begin fails++; $display("FAIL idle_after_reset outs=%h exp=000", outs); end
  endtask
  task automatic test_mult(input string nm, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] lo, input logic [7:0] hi, input int adds);
    logic [11:0] oa, ob;
    int n, s;
    launch(a, b, oa, ob);
    tests++;
    if (oa !== 12'hC80) begin fails++; $display("FAIL %s load_a outs=%h exp=c80", nm, oa); end
    tests++;
    if (ob !== 12'hC70) begin fails++; $display("FAIL %s load_b outs=%h exp=c70", nm, ob); end
    n = 0; s = 0;
    while (outs[2] && n < 20) begin
      if (sel_sum) s++;
      n++;
      @(negedge clk);
    end
    tests++;
    if (n != 8) begin fails++; $display("FAIL %s iter_cycles got=%0d exp=8", nm, n); end
    tests++;
    if (s != adds) begin fails++; $display("FAIL %s sel_sum_cycles got=%0d exp=%0d", nm, s, adds); end
    tests++;
    if (outs !== 12'hA02 || bus !== lo) begin fails++; $display("FAIL %s out_lo outs=%h bus=%h exp=a02/%h", nm, outs, bus, lo); end
    res_ack = 1;
    @(negedge clk) tests++;
    if (outs !== 12'h901 || bus !== hi) begin fails++; $display("FAIL %s out_hi outs=%h bus=%h exp=901/%h", nm, outs, bus, hi); end
    @(negedge clk) res_ack = 0;
    tests++;
    if (outs !== 12'h000) begin fails++; $display("FAIL %s back_idle outs=%h exp=000", nm, outs); end
  endtask
  task automatic test_start_ignored;
    logic [11:0] oa, ob;
    int n;
    launch(8'h0D, 8'h0B, oa, ob);
    n = 0;
    while (outs[2] && n < 20) begin
      start = (n == 2);
      n++;
      @(negedge clk);
    end
    start = 0;
    tests++;
    if (n != 8) begin fails++; $display("FAIL start_iter iter_cycles got=%0d exp=8", n); end
    start = 1;
    repeat (3) @(negedge clk);
    start = 0;
    tests++;
    if (outs !== 12'hA02 || bus !== 8'h8F) begin fails++; $display("FAIL start_out_lo outs=%h bus=%h exp=a02/8f", outs, bus); end
    res_ack = 1;
    @(negedge clk) tests++;
    if (outs !== 12'h901 || bus !== 8'h00) begin fails++; $display("FAIL start_out_hi outs=%h bus=%h exp=901/00", outs, bus); end
    @(negedge clk) res_ack = 0;
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL start_busy_drop busy=%b exp=0", busy); end
    repeat (12) @(negedge clk);
    tests++;
    if (outs !== 12'h000) begin fails++; $display("FAIL start_single_result outs=%h exp=000", outs); end
  endtask
  task automatic test_ack_hold;
    logic [11:0] oa, ob;
    logic [7:0] lo_seen;
    int n, h;
    launch(8'hFF, 8'hFF, oa, ob);
    n = 0;
    while (outs[2] && n < 20) begin n++; @(negedge clk); end
    lo_seen = bus;
    h = 0;
    for (int k = 0; k < 5; k++) begin
      if (outs === 12'hA02) h++;
      if (k == 4) res_ack = 1;
      @(negedge clk);
    end
    tests++;
    if (h != 5) begin fails++; $display("FAIL hold_lsb_cycles got=%0d exp=5", h); end
    tests++;
    if (lo_seen !== 8'h01) begin fails++; $display("FAIL hold_lo bus=%h exp=01", lo_seen); end
    tests++;
    if (outs !== 12'h901 || bus !== 8'hFE) begin fails++; $display("FAIL hold_out_hi outs=%h bus=%h exp=901/fe", outs, bus); end
    @(negedge clk) res_ack = 0;
    tests++;
    if (outs !== 12'h000) begin fails++; $display("FAIL hold_idle outs=%h exp=000", outs); end
  endtask
  task automatic test_ack_idle;
    res_ack = 1;
    repeat (3) @(negedge clk);
    tests++;
    if (outs !== 12'h000) begin fails++; $display("FAIL ack_in_idle outs=%h exp=000", outs); end
    res_ack = 0;
  endtask
  task automatic test_reset_mid;
    logic [11:0] oa, ob;
    launch(8'h0D, 8'h0B, oa, ob);
    repeat (3) @(negedge clk);
    tests++;
    if ((outs & ~12'h008) !== 12'h814) begin fails++; $display("FAIL rst_mid_iter outs=%h exp=814", outs); end
    rst_n = 0;
    #1 tests++;
    if (outs !== 12'h000) begin fails++; $display("FAIL rst_mid_async outs=%h exp=000", outs); end
    @(negedge clk) tests++;
    if (outs !== 12'h000) begin fails++; $display("FAIL rst_mid_held outs=%h exp=000", outs); end
    rst_n = 1;
    @(negedge clk);
    test_mult("after_rst", 8'h03, 8'h07, 8'h15, 8'h00, 2);
  endtask
  initial begin
    test_reset;
    test_mult("m13x11", 8'h0D, 8'h0B, 8'h8F, 8'h00, 3);
    test_mult("mffxff", 8'hFF, 8'hFF, 8'h01, 8'hFE, 8);
    test_mult("m00x5a", 8'h00, 8'h5A, 8'h00, 8'h00, 0);
    test_start_ignored;
    test_ack_hold;
    test_ack_idle;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
